// File: rtl/snake_pkg.sv
// Shared constants and tile encodings for the snake game video/board path.
package snake_pkg;

    localparam int unsigned H_ACTIVE  = 640;
    localparam int unsigned H_TOTAL   = 800;
    localparam int unsigned V_ACTIVE  = 480;
    localparam int unsigned V_TOTAL   = 525;
    localparam int unsigned CELL_LOG2 = 4;
    localparam int unsigned COLS      = 40;
    localparam int unsigned ROWS      = 30;
    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned DATA_W    = 4;

    typedef enum logic [DATA_W-1:0] {
        TILE_EMPTY      = 4'd0,
        TILE_SNAKE_BODY = 4'd1,
        TILE_SNAKE_HEAD = 4'd2,
        TILE_FOOD       = 4'd3,
        TILE_WALL       = 4'd4
    } tile_e;

    // row*COLS without a multiplier: 40 = 32 + 8.
    function automatic logic [ADDR_W-1:0] row_base(input logic [5:0] row);
        logic [ADDR_W-1:0] r;
        r = {5'b0, row};
        return (r << 5) + (r << 3);
    endfunction

endpackage

// File: rtl/render_fetch_sched.sv
// Decides, from the VGA counters alone, whether this cycle is a render fetch slot
// and which board cell it reads: the next cell on this line, or column 0 of the next line.
module render_fetch_sched
    import snake_pkg::*;
(
    input  logic              pix_en,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    output logic              slot,
    output logic [ADDR_W-1:0] addr
);

    logic       phase;
    logic       case_a;
    logic       case_b;
    logic [9:0] nl;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        slot   = 1'b0;
        addr   = '0;
        phase  = pix_en && (hcount[3:0] == 4'd8);
        nl     = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
        case_a = (hcount < 10'(H_ACTIVE - 16)) && (vcount < 10'(V_ACTIVE));
        case_b = (hcount == 10'(H_TOTAL - 8)) && (nl < 10'(V_ACTIVE));

        if (phase && case_a) begin
            slot = 1'b1;
            addr = row_base(vcount[9:4]) + {5'b0, hcount[9:4]} + 11'd1;
        end else if (phase && case_b) begin
            slot = 1'b1;
            addr = row_base(nl[9:4]);
        end
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// Shares the board RAM between the fixed-schedule render prefetcher (always wins)
// and the game-logic req/gnt port; stages fetched tile codes for the pixel mux.
module board_mem_arbiter
    import snake_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              lg_req,
    input  logic              lg_we,
    input  logic [ADDR_W-1:0] lg_addr,
    input  logic [DATA_W-1:0] lg_wdata,
    output logic              lg_gnt,
    output logic              lg_rvalid,
    output logic [DATA_W-1:0] lg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] tile_code
);

    logic              slot;
    logic [ADDR_W-1:0] rf_addr;

    logic [DATA_W-1:0] tile_code_q, tile_code_d;
    logic [DATA_W-1:0] next_code_q, next_code_d;
    logic              render_pend_q, render_pend_d;
    logic              lg_rvalid_q, lg_rvalid_d;

    render_fetch_sched u_sched (
        .pix_en (pix_en),
        .hcount (hcount),
        .vcount (vcount),
        .slot   (slot),
        .addr   (rf_addr)
    );

    always_comb begin
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        lg_gnt        = 1'b0;
        lg_rvalid_d   = 1'b0;
        render_pend_d = slot;
        next_code_d   = render_pend_q ? mem_rdata : next_code_q;
        tile_code_d   = (pix_en && hcount[3:0] == 4'd15) ? next_code_q : tile_code_q;

        if (slot) begin
            mem_en   = 1'b1;
            mem_addr = rf_addr;
        end else if (lg_req) begin
            mem_en      = 1'b1;
            mem_we      = lg_we;
            mem_addr    = lg_addr;
            mem_wdata   = lg_wdata;
            lg_gnt      = 1'b1;
            lg_rvalid_d = !lg_we;
        end
    end

    // NOTE: state updates use non-blocking assignments; reset is synchronous, so it only acts on a clk edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tile_code_q   <= '0;
            next_code_q   <= '0;
            render_pend_q <= 1'b0;
            lg_rvalid_q   <= 1'b0;
        end else begin
            tile_code_q   <= tile_code_d;
            next_code_q   <= next_code_d;
            render_pend_q <= render_pend_d;
            lg_rvalid_q   <= lg_rvalid_d;
        end
    end

    // RAM output is already registered; it is presented as-is in the valid cycle.
    assign lg_rdata  = mem_rdata;
    assign lg_rvalid = lg_rvalid_q;
    assign tile_code = tile_code_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a behavioural sync-read board RAM.
module tb_board_mem_arbiter;
    import snake_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              pix_en;
    logic [9:0]        hcount;
    logic [9:0]        vcount;
    logic              lg_req;
    logic              lg_we;
    logic [ADDR_W-1:0] lg_addr;
    logic [DATA_W-1:0] lg_wdata;
    logic              lg_gnt;
    logic              lg_rvalid;
    logic [DATA_W-1:0] lg_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] tile_code;

    int total;
    int bad;

    logic [DATA_W-1:0] ram [0:2047];

    board_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_en    (pix_en),
        .hcount    (hcount),
        .vcount    (vcount),
        .lg_req    (lg_req),
        .lg_we     (lg_we),
        .lg_addr   (lg_addr),
        .lg_wdata  (lg_wdata),
        .lg_gnt    (lg_gnt),
        .lg_rvalid (lg_rvalid),
        .lg_rdata  (lg_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .tile_code (tile_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        string             name;
        logic              pix_en;
        logic [9:0]        h;
        logic [9:0]        v;
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic              e_en;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic              e_gnt;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pe, input logic [9:0] h, input logic [9:0] v,
                         input logic req, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd);
        pix_en   = pe;
        hcount   = h;
        vcount   = v;
        lg_req   = req;
        lg_we    = we;
        lg_addr  = a;
        lg_wdata = wd;
    endtask

    task automatic logic_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        drive(1'b0, 10'd0, 10'd500, 1'b1, 1'b1, a, wd);
        @(negedge clk);
        check($sformatf("wr_gnt_%0d", a), 32'(lg_gnt), 32'd1);
        next_cycle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 2048; i++) ram[i] = '0;
        mem_rdata = '0;
        rst_n = 1'b0;
        drive(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, '0, '0);

        // Power-on reset.
        repeat (3) next_cycle();
        @(negedge clk);
        check("por_tile_code", 32'(tile_code), 32'd0);
        check("por_rvalid", 32'(lg_rvalid), 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // Combinational schedule/arbitration table.
        vecs[0]  = '{"A_h24_v35",     1'b1, 10'd24,  10'd35,  1'b1, 1'b0, 11'd7,   1'b1, 1'b0, 11'd82,   1'b0};
        vecs[1]  = '{"none_h632",     1'b1, 10'd632, 10'd35,  1'b0, 1'b0, 11'd0,   1'b0, 1'b0, 11'd0,    1'b0};
        vecs[2]  = '{"B_v524_wrap",   1'b1, 10'd792, 10'd524, 1'b0, 1'b0, 11'd0,   1'b1, 1'b0, 11'd0,    1'b0};
        vecs[3]  = '{"B_v479_none",   1'b1, 10'd792, 10'd479, 1'b0, 1'b0, 11'd0,   1'b0, 1'b0, 11'd0,    1'b0};
        vecs[4]  = '{"B_v15_row1",    1'b1, 10'd792, 10'd15,  1'b0, 1'b0, 11'd0,   1'b1, 1'b0, 11'd40,   1'b0};
        vecs[5]  = '{"lg_wr_nopix",   1'b0, 10'd24,  10'd35,  1'b1, 1'b1, 11'd200, 1'b1, 1'b1, 11'd200,  1'b1};
        vecs[6]  = '{"A_h8_v0",       1'b1, 10'd8,   10'd0,   1'b0, 1'b0, 11'd0,   1'b1, 1'b0, 11'd1,    1'b0};
        vecs[7]  = '{"A_last_cell",   1'b1, 10'd616, 10'd479, 1'b0, 1'b0, 11'd0,   1'b1, 1'b0, 11'd1199, 1'b0};
        vecs[8]  = '{"off_phase",     1'b1, 10'd25,  10'd0,   1'b0, 1'b0, 11'd0,   1'b0, 1'b0, 11'd0,    1'b0};
        vecs[9]  = '{"vblank_lg_rd",  1'b1, 10'd40,  10'd480, 1'b1, 1'b0, 11'd5,   1'b1, 1'b0, 11'd5,    1'b1};
        vecs[10] = '{"B_v523_none",   1'b1, 10'd792, 10'd523, 1'b0, 1'b0, 11'd0,   1'b0, 1'b0, 11'd0,    1'b0};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].pix_en, vecs[i].h, vecs[i].v, vecs[i].req, vecs[i].we, vecs[i].addr, '0);
            @(negedge clk);
            check({vecs[i].name, "_en"},  32'(mem_en), 32'(vecs[i].e_en));
            check({vecs[i].name, "_gnt"}, 32'(lg_gnt), 32'(vecs[i].e_gnt));
            if (vecs[i].e_en) begin
                check({vecs[i].name, "_we"},   32'(mem_we),   32'(vecs[i].e_we));
                check({vecs[i].name, "_addr"}, 32'(mem_addr), 32'(vecs[i].e_addr));
            end
            next_cycle();
        end

        // Preload board cells through the logic port during vblank.
        logic_write(11'd41,  TILE_FOOD);
        logic_write(11'd42,  4'h5);
        logic_write(11'd44,  4'h7);
        logic_write(11'd100, 4'hA);

        // Write visibility on line 16: cell 1 shows the freshly written code.
        for (int h = 0; h <= 40; h++) begin
            drive(1'b1, 10'(h), 10'd16, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            if (h == 16) check("vis_h16", 32'(tile_code), 32'h3);
            if (h == 31) check("vis_h31", 32'(tile_code), 32'h3);
            if (h == 32) check("vis_h32", 32'(tile_code), 32'h5);
            next_cycle();
        end

        // Collision: render slot at hcount=8 beats a held logic read of addr 100.
        drive(1'b1, 10'd8, 10'd100, 1'b1, 1'b0, 11'd100, '0);
        @(negedge clk);
        check("col_gnt_slot", 32'(lg_gnt), 32'd0);
        check("col_addr_slot", 32'(mem_addr), 32'd241);
        next_cycle();
        drive(1'b1, 10'd9, 10'd100, 1'b1, 1'b0, 11'd100, '0);
        @(negedge clk);
        check("col_gnt_next", 32'(lg_gnt), 32'd1);
        check("col_addr_next", 32'(mem_addr), 32'd100);
        next_cycle();
        drive(1'b1, 10'd10, 10'd100, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("col_rvalid", 32'(lg_rvalid), 32'd1);
        check("col_rdata", 32'(lg_rdata), 32'hA);
        next_cycle();
        drive(1'b1, 10'd11, 10'd100, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("col_rvalid_pulse", 32'(lg_rvalid), 32'd0);
        next_cycle();

        // Mid-line reset: render fetch of cell 44 (=7) in flight, read granted at the reset edge.
        drive(1'b1, 10'd56, 10'd16, 1'b0, 1'b0, '0, '0);
        next_cycle();
        rst_n = 1'b0;
        drive(1'b0, 10'd57, 10'd16, 1'b1, 1'b0, 11'd100, '0);
        next_cycle();
        drive(1'b0, 10'd58, 10'd16, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rst_rvalid_1", 32'(lg_rvalid), 32'd0);
        check("rst_tile_1", 32'(tile_code), 32'd0);
        next_cycle();
        @(negedge clk);
        check("rst_rvalid_2", 32'(lg_rvalid), 32'd0);
        check("rst_tile_2", 32'(tile_code), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        drive(1'b1, 10'd63, 10'd16, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rst_rvalid_3", 32'(lg_rvalid), 32'd0);
        next_cycle();
        drive(1'b1, 10'd64, 10'd16, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rst_no_capture", 32'(tile_code), 32'd0);
        next_cycle();

        // Streaming: ten back-to-back writes during vblank, no render slots.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 10'(i), 10'd500, 1'b1, 1'b1, 11'(300 + i), 4'(i + 1));
            @(negedge clk);
            check($sformatf("stream_gnt_%0d", i), 32'(lg_gnt), 32'd1);
            next_cycle();
        end
        drive(1'b0, 10'd10, 10'd500, 1'b0, 1'b0, '0, '0);
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stream_ram_%0d", i), 32'(ram[300 + i]), 32'(i + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
